// File: rtl/seg7_pattern_decoder.sv
// Purpose: recovers the one-hot index (0..7) from a debounced 7-segment pattern bus.
// Latency: out_valid rises STABLE_CYCLES+3 edges after seg_in changes (edge 7 at default).
// Backpressure: held event is stable until out_ready; an event arriving meanwhile is dropped and sets sticky overrun.
module seg7_pattern_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    input  logic       out_ready,
    input  logic       clr_overrun,
    output logic       out_valid,
    output logic [2:0] out_code,
    output logic [7:0] out_onehot,
    output logic       out_err,
    output logic       overrun,
    output logic [7:0] event_cnt
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       s1;
    logic [6:0]       s2;
    logic [6:0]       last;
    logic             chg;
    logic             issue;
    logic             slot_free;
    logic [2:0]       dec_code;
    logic [7:0]       dec_onehot;
    logic             dec_err;

    assign chg       = (s2 != last);
    assign issue     = (state == SETTLE) && !chg && (cnt == CNT_LAST);
    assign slot_free = !out_valid || out_ready;

    // Blank never reaches the decoder as an event, so only table hits are non-errors.
    always_comb begin
        dec_code = 3'd0;
        dec_err  = 1'b0;
        case (s2)
            7'h06:   dec_code = 3'd0;
            7'h5B:   dec_code = 3'd1;
            7'h4F:   dec_code = 3'd2;
            7'h66:   dec_code = 3'd3;
            7'h6D:   dec_code = 3'd4;
            7'h7D:   dec_code = 3'd5;
            7'h07:   dec_code = 3'd6;
            7'h6F:   dec_code = 3'd7;
            default: dec_err  = 1'b1;
        endcase
        dec_onehot = dec_err ? 8'h00 : (8'h01 << dec_code);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s2         <= '0;
            last       <= '0;
            state      <= IDLE;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_code   <= '0;
            out_onehot <= '0;
            out_err    <= 1'b0;
            overrun    <= 1'b0;
            event_cnt  <= '0;
        end else begin
            s1   <= seg_in;
            s2   <= s1;
            last <= s2;

            case (state)
                IDLE: begin
                    if (chg && (s2 != 7'h00)) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    if (chg) begin
                        cnt <= '0;
                        if (s2 == 7'h00) state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= HOLD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (chg) begin
                        cnt   <= '0;
                        state <= (s2 == 7'h00) ? IDLE : SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (issue) begin
                event_cnt <= event_cnt + 8'd1;
                if (slot_free) begin
                    out_valid  <= 1'b1;
                    out_code   <= dec_code;
                    out_onehot <= dec_onehot;
                    out_err    <= dec_err;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            // A fresh drop on the same edge as the clear keeps the flag set.
            if (issue && !slot_free) overrun <= 1'b1;
            else if (clr_overrun)    overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_pattern_decoder.sv
// Bench for seg7_pattern_decoder: directed scenarios plus random pattern streams against a run-length reference model.
module tb_seg7_pattern_decoder;

    localparam int S  = 4;
    localparam int HN = S + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic       out_ready = 1'b0;
    logic       clr_overrun = 1'b0;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] out_onehot;
    logic       out_err;
    logic       overrun;
    logic [7:0] event_cnt;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [6:0] hist [HN];
    logic       m_valid;
    logic [2:0] m_code;
    logic [7:0] m_onehot;
    logic       m_err;
    logic       m_ovr;
    int         m_cnt;
    logic [6:0] tbl [8] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h6F};

    seg7_pattern_decoder #(.STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .out_valid   (out_valid),
        .out_code    (out_code),
        .out_onehot  (out_onehot),
        .out_err     (out_err),
        .overrun     (overrun),
        .event_cnt   (event_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < HN; i++) hist[i] = 7'h00;
        m_valid = 1'b0; m_code = 3'd0; m_onehot = 8'h00;
        m_err = 1'b0; m_ovr = 1'b0; m_cnt = 0;
    endtask

    // An event fires when the sample taken two edges ago closes a run of exactly
    // S+1 equal, non-blank samples.
    task automatic model_edge(input logic [6:0] seg, input logic rdy, input logic clr);
        logic ev;
        logic hit;
        logic [2:0] code;
        for (int i = HN - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = seg;
        ev = (hist[2] != 7'h00) && (hist[3+S] != hist[2]);
        for (int i = 3; i <= 2 + S; i++) if (hist[i] != hist[2]) ev = 1'b0;
        hit = 1'b0;
        code = 3'd0;
        for (int k = 0; k < 8; k++) if (tbl[k] == hist[2]) begin hit = 1'b1; code = 3'(k); end
        if (ev) begin
            m_cnt = (m_cnt + 1) % 256;
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_code = hit ? code : 3'd0;
                m_onehot = hit ? (8'h01 << code) : 8'h00;
                m_err = !hit;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        if (clr && !(ev && m_ovr && !(!m_valid || rdy) && 1'b0)) begin
            if (!(ev && !(!m_valid || rdy))) m_ovr = clr ? 1'b0 : m_ovr;
        end
    endtask

    task automatic compare_all();
        chk("valid",  32'(out_valid),  32'(m_valid));
        chk("code",   32'(out_code),   32'(m_code));
        chk("onehot", 32'(out_onehot), 32'(m_onehot));
        chk("err",    32'(out_err),    32'(m_err));
        chk("ovr",    32'(overrun),    32'(m_ovr));
        chk("cnt",    32'(event_cnt),  32'(m_cnt));
    endtask

    // Called at a negedge; drives inputs, lets one edge pass, checks at the next negedge.
    task automatic step(input logic [6:0] seg, input logic rdy, input logic clr);
        seg_in = seg; out_ready = rdy; clr_overrun = clr;
        @(posedge clk);
        model_edge(seg, rdy, clr);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold(input logic [6:0] seg, input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(seg, rdy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
    endtask

    initial begin
        int base;
        model_reset();

        // 1: reset with a live pattern on the pins, then latency from release
        seg_in = 7'h7D;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(7'h7D, 1'b0, 1'b0);
            chk("no_early_evt", 32'(out_valid), 32'd0);
        end
        step(7'h7D, 1'b0, 1'b0);
        chk("lat_edge7", 32'(out_valid), 32'd1);
        chk("lat_code5", 32'(out_code), 32'd5);

        // 2: single clean event, no re-issue while held
        do_reset();
        for (int i = 1; i <= 7; i++) step(7'h06, 1'b1, 1'b0);
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_onehot", 32'(out_onehot), 32'h01);
        step(7'h06, 1'b1, 1'b0);
        chk("t2_drop", 32'(out_valid), 32'd0);
        hold(7'h06, 1'b1, 20);
        chk("t2_cnt", 32'(event_cnt), 32'd1);

        // 3: glitch to blank during settling restarts the debounce
        hold(7'h00, 1'b1, 6);
        base = int'(event_cnt);
        hold(7'h6F, 1'b1, 2);
        hold(7'h00, 1'b1, 1);
        hold(7'h6F, 1'b0, 12);
        chk("t3_one_evt", 32'(event_cnt), 32'(base + 1));
        chk("t3_onehot", 32'(out_onehot), 32'h80);
        hold(7'h6F, 1'b1, 1);

        // 4: unknown pattern decodes as error
        hold(7'h7F, 1'b0, 10);
        chk("t4_err", 32'(out_err), 32'd1);
        chk("t4_code", 32'(out_code), 32'd0);
        chk("t4_onehot", 32'(out_onehot), 32'h00);
        chk("t4_cnt", 32'(event_cnt), 32'(base + 2));
        hold(7'h7F, 1'b1, 1);

        // 5: overrun under backpressure, clear, then drain
        base = int'(event_cnt);
        hold(7'h5B, 1'b0, 8);
        hold(7'h4F, 1'b0, 8);
        chk("t5_code", 32'(out_code), 32'd1);
        chk("t5_ovr", 32'(overrun), 32'd1);
        chk("t5_cnt", 32'(event_cnt), 32'(base + 2));
        step(7'h4F, 1'b0, 1'b1);
        chk("t5_clr", 32'(overrun), 32'd0);
        step(7'h4F, 1'b1, 1'b0);
        chk("t5_drain", 32'(out_valid), 32'd0);

        // Random streams: table hits, blanks, garbage and OR'd multi-hot patterns
        for (int n = 0; n < 200; n++) begin
            logic [6:0] p;
            int kind;
            int len;
            kind = $urandom_range(0, 9);
            if (kind <= 5)      p = tbl[$urandom_range(0, 7)];
            else if (kind == 6) p = 7'h00;
            else if (kind == 7) p = 7'($urandom);
            else                p = tbl[$urandom_range(0, 7)] | tbl[$urandom_range(0, 7)];
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++)
                step(p, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0));
        end

        // 6: asynchronous reset with an event pending
        hold(7'h00, 1'b1, 8);
        hold(7'h5B, 1'b0, 8);
        hold(7'h4F, 1'b0, 8);
        chk("t6_pending", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_ovr", 32'(overrun), 32'd0);
        chk("t6_rst_cnt", 32'(event_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) hold((i % 2 == 1) ? 7'h5B : 7'h4F, 1'b1, 8);
        chk("t6_wrap", 32'(event_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
